// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide responder owning the HI/LO registers.
// A one-cycle start in IDLE launches MULT/MULTU/DIV/DIVU (busy for a fixed
// cycle count, then a one-cycle done as HI/LO commit) or writes HI/LO directly
// for MTHI/MTLO. Requests arriving while busy are dropped.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   hin_q, lon_q;

  op_e           op_c;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   mag_a, mag_b, dvs_s, dvs_u;
  logic [31:0]   quo_s, rem_s, quo_u, rem_u;
  logic [31:0]   res_hi_d, res_lo_d;

  assign op_c = op_e'(op);

  // Result of the requested operation, computed from the operands in the start cycle.
  always_comb begin
    prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u   = {32'b0, a} * {32'b0, b};
    // Signed divide works on magnitudes; 0x8000_0000 / -1 falls out naturally
    // because the negated magnitude wraps back to 0x8000_0000.
    mag_a    = a[31] ? -a : a;
    mag_b    = b[31] ? -b : b;
    dvs_s    = (b == '0) ? 32'd1 : mag_b;
    dvs_u    = (b == '0) ? 32'd1 : b;
    quo_s    = mag_a / dvs_s;
    rem_s    = mag_a % dvs_s;
    quo_u    = a / dvs_u;
    rem_u    = a % dvs_u;
    res_hi_d = '0;
    res_lo_d = '0;
    case (op_c)
      OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
      OP_DIV: begin
        if (b == '0) begin
          res_hi_d = a;
          res_lo_d = '1;
        end else begin
          res_hi_d = a[31] ? -rem_s : rem_s;
          res_lo_d = (a[31] ^ b[31]) ? -quo_s : quo_s;
        end
      end
      OP_DIVU: begin
        if (b == '0) begin
          res_hi_d = a;
          res_lo_d = '1;
        end else begin
          res_hi_d = rem_u;
          res_lo_d = quo_u;
        end
      end
      default: begin
        res_hi_d = '0;
        res_lo_d = '0;
      end
    endcase
  end

  // Control FSM, countdown and HI/LO ownership; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hin_q   <= '0;
      lon_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op_c)
              OP_MULT, OP_MULTU: begin
                hin_q   <= res_hi_d;
                lon_q   <= res_lo_d;
                cnt_q   <= MULT_LOAD;
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                hin_q   <= res_hi_d;
                lon_q   <= res_lo_d;
                cnt_q   <= DIV_LOAD;
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= hin_q;
            lo_q    <= lon_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide responder for the pipelined MIPS core.
- The E-stage issues a one-cycle start request, and the unit answers with busy until the result is committed to HI/LO.
- The stall controller reads busy/start to freeze the pipeline when a later mult/div/mfhi/mflo arrives.
- The unit owns the architectural HI and LO registers.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (≥1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request strobe from E stage.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op.
- a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- b  input  32  rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse in the cycle HI/LO take the new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0, counter=0, state=IDLE.
  - Any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE:
  - start=1 with op 0-3: latch a, b and op; compute result into internal hi_n/lo_n; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy=1 from the next edge.
  - start=1 with op 4 (MTHI): hi<=a at this edge. busy stays 0.
  - start=1 with op 5 (MTLO): lo<=a at this edge. busy stays 0.
  - start=1 with op 6-7: ignored.
  - start=0: hold.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter goes 1→0: hi<=hi_n, lo<=lo_n, busy<=0, done<=1 for one cycle, state=IDLE.
  - Result: busy high exactly N cycles; new hi/lo visible in cycle N+1 after the start cycle (N = MULT_CYCLES or DIV_CYCLES).
- start while busy=1 (any op): ignored. HI/LO and counter are unaffected.
  - The stall controller guarantees this does not happen. The unit still does not corrupt state.
- Start on the completion cycle: not accepted, because busy is still 1 in that cycle. It is accepted one cycle later.
- hi/lo outputs hold their old values throughout RUN. mfhi/mflo are stalled by the pipeline, not by this block.
- Arithmetic:
  - MULT: signed 32×32→64; hi=upper 32, lo=lower 32.
  - MULTU: unsigned 32×32→64; hi=upper 32, lo=lower 32.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (DIV or DIVU): lo=32'hFFFF_FFFF, hi=a. Busy for full DIV_CYCLES.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. No exception.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done pulse.
- done=0 in every cycle except the commit cycle.

Test Plan:
- Reset release, then start op=0 (MULT), a=-3 (32'hFFFF_FFFD), b=7 -> busy high 5 cycles, done pulses once; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- MULTU a=32'hFFFF_FFFF, b=2 -> hi=1, lo=32'hFFFF_FFFE.
- DIV a=-7, b=2 -> busy 10 cycles; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- DIVU a=7, b=0 -> lo=32'hFFFF_FFFF, hi=7.
- DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- MTHI a=32'h1234_5678 in IDLE -> hi=32'h1234_5678 after 1 edge, busy stays 0.
- MTLO during RUN -> lo unchanged until commit.
- start MULT, pull reset low at cycle 3 -> busy=0, hi=lo=0 immediately; no done pulse.
